pellet_eat_ctrl: RTL and testbench

//  Upstream stage of the food map: once per frame, decides whether Pac-Man has reached the centre of a pellet tile.
//  On a hit: fires the one-cycle is_food_eaten strobe that clears the pellet, adds points to a BCD score,

---
 rtl/pacman_pkg.sv | 39 +++
 rtl/bcd_add_sat.sv | 41 ++++
 rtl/pellet_eat_ctrl.sv | 134 +++++++++++++
 tb/tb_pellet_eat_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared constants and types for the Pac-Man pellet logic.
//   MAP_COLS / MAP_ROWS : maze size in tiles; tile index = row*MAP_COLS + col
//   TILE_SHIFT          : log2 of tile size in pixels
//   CENTER_WIN          : how far (in pixels) from a tile centre still counts as "on" it
//   PELLET_TOTAL        : pellets in a fresh maze
//   PELLET_PTS_BCD      : points per pellet, already in BCD
//   tile_idx_t, TILE_NONE, eat_state_t, is_centred()
package pacman_pkg;

    localparam int MAP_COLS     = 20;
    localparam int MAP_ROWS     = 11;
    localparam int TILE_SHIFT   = 5;
    localparam int TILE_HALF    = 1 << (TILE_SHIFT - 1);
    localparam int CENTER_WIN   = 2;
    localparam int PELLET_TOTAL = 150;
    localparam int PELLET_PTS   = 10;

    // Same value as PELLET_PTS, pre-encoded so the score adder never needs a binary-to-BCD step.
    localparam logic [7:0] PELLET_PTS_BCD = 8'h10;

    typedef logic [7:0] tile_idx_t;

    // Never a valid tile (the maze stops at 219), so it means "no tile eaten yet".
    localparam tile_idx_t TILE_NONE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        LOOKUP,
        CHECK
    } eat_state_t;

    // The pixel offset inside a tile lies within CENTER_WIN of the tile centre.
    function automatic logic is_centred(input logic [TILE_SHIFT-1:0] off);
        return (off >= TILE_SHIFT'(TILE_HALF - CENTER_WIN)) &&
               (off <= TILE_SHIFT'(TILE_HALF + CENTER_WIN));
    endfunction

endpackage

// File: rtl/bcd_add_sat.sv
// 4-digit BCD accumulator step: sum = a + b, saturating at 9999.
//   a   : 16-bit BCD running value (4 digits)
//   b   : 8-bit BCD increment (2 digits)
//   sum : 16-bit BCD result, 16'h9999 when the add carries out of the top digit
// Purely combinational. Inputs are assumed to hold valid BCD digits.
module bcd_add_sat (
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic [15:0] sum
);

    logic [15:0] b_ext;
    logic [15:0] raw;
    logic        carry_out;

    assign b_ext = {8'h00, b};

    always_comb begin
        logic       c;
        logic [4:0] d;
        // NOTE: every variable written here gets a value before any branch reads or skips it,
        // so no path leaves a previous value held and no latch is inferred.
        c   = 1'b0;
        d   = 5'd0;
        raw = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b_ext[4*i +: 4]} + {4'd0, c};
            if (d > 5'd9) begin
                d = d - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            raw[4*i +: 4] = d[3:0];
        end
        carry_out = c;
    end

    assign sum = carry_out ? 16'h9999 : raw;

endmodule

// File: rtl/pellet_eat_ctrl.sv
// Pellet-eating controller: once per frame, decides whether Pac-Man sits on the centre of a
// tile that still holds a pellet, and if so clears it, scores it and counts it down.
//   Clk, Reset_n      : system clock, asynchronous active-low reset
//   frame_clk         : per-frame tick from another clock domain; each rising edge starts one evaluation
//   level_restart     : 1-cycle pulse; reload pellet count, clear level_clear and the last-eaten tile
//   Ball_X/Y_Pos_out  : Pac-Man centre, pixels
//   query_addr        : tile index for the food map query port
//   food_tile_n       : food map answer for query_addr one cycle later (0 = pellet present)
//   is_food_eaten     : 1-cycle strobe telling the food map to clear the current tile
//   score_bcd         : 4-digit BCD score, saturating at 9999
//   pellets_left      : pellets still in the maze
//   level_clear       : sticky, set when the last pellet is eaten
module pellet_eat_ctrl
    import pacman_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        level_restart,
    input  logic [9:0]  Ball_X_Pos_out,
    input  logic [9:0]  Ball_Y_Pos_out,
    output tile_idx_t   query_addr,
    input  logic        food_tile_n,
    output logic        is_food_eaten,
    output logic [15:0] score_bcd,
    output logic [7:0]  pellets_left,
    output logic        level_clear
);

    // ---------------- frame_clk synchroniser and rising-edge detect ----------------
    logic [1:0] frame_sync;
    logic       frame_prev;
    logic       frame_edge;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_sync <= 2'b00;
            frame_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop here sample the old value of its
            // neighbour, which is exactly what builds a shift chain rather than one wire.
            frame_sync <= {frame_sync[0], frame_clk};
            frame_prev <= frame_sync[1];
        end
    end

    assign frame_edge = frame_sync[1] & ~frame_prev;

    // ---------------- tile decode for the SAMPLE cycle ----------------
    logic [9-TILE_SHIFT:0] col;
    logic [9-TILE_SHIFT:0] row;
    tile_idx_t             sample_tile;
    logic                  sample_ok;

    eat_state_t state;
    tile_idx_t  last_tile;

    assign col = Ball_X_Pos_out[9:TILE_SHIFT];
    assign row = Ball_Y_Pos_out[9:TILE_SHIFT];

    // Only meaningful when the tile is inside the maze; sample_ok filters the rest.
    assign sample_tile = {3'b000, row} * 8'(MAP_COLS) + {3'b000, col};

    assign sample_ok = (col < (10-TILE_SHIFT)'(MAP_COLS)) &&
                       (row < (10-TILE_SHIFT)'(MAP_ROWS)) &&
                       is_centred(Ball_X_Pos_out[TILE_SHIFT-1:0]) &&
                       is_centred(Ball_Y_Pos_out[TILE_SHIFT-1:0]) &&
                       !level_clear &&
                       (sample_tile != last_tile);

    // ---------------- hit decision ----------------
    // The food map answer only arrives during CHECK, and the strobe must be high in that
    // same cycle, so the strobe is decoded from state and data instead of being registered.
    // A restart pulse in the same cycle suppresses it.
    logic        eat_hit;
    logic [15:0] score_next;

    assign eat_hit       = (state == CHECK) && !food_tile_n &&
                           (pellets_left != 8'd0) && !level_restart;
    assign is_food_eaten = eat_hit;

    bcd_add_sat u_score_add (
        .a   (score_bcd),
        .b   (PELLET_PTS_BCD),
        .sum (score_next)
    );

    // ---------------- FSM and registered datapath ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            query_addr   <= '0;
            last_tile    <= TILE_NONE;
            score_bcd    <= 16'h0000;
            pellets_left <= 8'(PELLET_TOTAL);
            level_clear  <= 1'b0;
        end else if (level_restart) begin
            // Score survives a restart; everything describing the current maze does not.
            state        <= IDLE;
            last_tile    <= TILE_NONE;
            pellets_left <= 8'(PELLET_TOTAL);
            level_clear  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Edges that land while an evaluation is in flight are simply lost.
                    if (frame_edge) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (sample_ok) begin
                        query_addr <= sample_tile;
                        state      <= LOOKUP;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOOKUP: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (eat_hit) begin
                        last_tile    <= query_addr;
                        score_bcd    <= score_next;
                        pellets_left <= pellets_left - 8'd1;
                        if (pellets_left == 8'd1) level_clear <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pellet_eat_ctrl.sv
module tb_pellet_eat_ctrl;

    localparam int NTILES = 220;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic        level_restart;
    logic [9:0]  Ball_X_Pos_out;
    logic [9:0]  Ball_Y_Pos_out;
    logic [7:0]  query_addr;
    logic        food_tile_n;
    logic        is_food_eaten;
    logic [15:0] score_bcd;
    logic [7:0]  pellets_left;
    logic        level_clear;

    pellet_eat_ctrl dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .frame_clk      (frame_clk),
        .level_restart  (level_restart),
        .Ball_X_Pos_out (Ball_X_Pos_out),
        .Ball_Y_Pos_out (Ball_Y_Pos_out),
        .query_addr     (query_addr),
        .food_tile_n    (food_tile_n),
        .is_food_eaten  (is_food_eaten),
        .score_bcd      (score_bcd),
        .pellets_left   (pellets_left),
        .level_clear    (level_clear)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Food map contents as the bench sees them: 1 = no pellet.
    bit map_empty [NTILES];

    // Reference model state.
    int m_score;
    int m_pellets;
    int m_last;
    bit m_clear;
    int m_qaddr;
    bit m_strobe;
    bit cmp_en = 1'b0;

    // Observations from the most recent frame.
    int obs_q;
    bit obs_s5;
    bit obs_s6;

    logic [7:0] q_seen;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit centred(input int p);
        int d;
        d = (p % 32) - 16;
        return (d >= -2) && (d <= 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_score   = 0;
        m_pellets = 150;
        m_clear   = 1'b0;
        m_last    = -1;
        m_qaddr   = 0;
        m_strobe  = 1'b0;
    endtask

    task automatic model_restart();
        m_pellets = 150;
        m_clear   = 1'b0;
        m_last    = -1;
    endtask

    task automatic fill_map();
        for (int i = 0; i < NTILES; i++) map_empty[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge Clk);
            if (cmp_en) begin
                check("strobe",  {31'd0, is_food_eaten}, {31'd0, m_strobe});
                check("score",   {16'd0, score_bcd},     {16'd0, to_bcd(m_score)});
                check("pellets", {24'd0, pellets_left},  m_pellets);
                check("clear",   {31'd0, level_clear},   {31'd0, m_clear});
                check("qaddr",   {24'd0, query_addr},    m_qaddr);
            end
        end
    end

    // Food map query port: answer for the address seen last cycle.
    initial begin
        food_tile_n = 1'b1;
        forever begin
            @(negedge Clk);
            q_seen = query_addr;
            @(posedge Clk);
            #1;
            food_tile_n = (q_seen < NTILES) ? map_empty[q_seen] : 1'b1;
        end
    end

    // One frame evaluation. Starts and ends #1 after a rising clock edge (cycle C0).
    // frame_clk rises in C0, the synchroniser sees the edge in C2 (E), lookup address in C4,
    // strobe in C5, register updates visible in C6.
    task automatic frame(input int x, input int y, input bit restart_at_check, input bit reset_at_lookup);
        int col;
        int row;
        int tile;
        bit look;
        bit hit;
        col  = x / 32;
        row  = y / 32;
        tile = row * 20 + col;
        look = (col < 20) && (row < 11) && centred(x) && centred(y) && !m_clear && (tile != m_last);
        hit  = look ? (!map_empty[tile] && (m_pellets > 0)) : 1'b0;

        Ball_X_Pos_out = x[9:0];
        Ball_Y_Pos_out = y[9:0];
        frame_clk = 1'b1;
        tick();
        tick();
        tick();
        frame_clk = 1'b0;
        tick();
        if (reset_at_lookup) begin
            Reset_n = 1'b0;
            #2;
            Reset_n = 1'b1;
            model_reset();
            hit = 1'b0;
        end else if (look) begin
            m_qaddr = tile;
        end
        @(negedge Clk);
        obs_q = query_addr;
        tick();
        m_strobe = hit && !restart_at_check;
        if (restart_at_check) level_restart = 1'b1;
        @(negedge Clk);
        obs_s5 = is_food_eaten;
        tick();
        m_strobe = 1'b0;
        if (restart_at_check) begin
            level_restart = 1'b0;
            model_restart();
        end else if (hit) begin
            m_score = (m_score + 10 > 9999) ? 9999 : m_score + 10;
            m_pellets--;
            m_last = tile;
            map_empty[tile] = 1'b1;
            if (m_pellets == 0) m_clear = 1'b1;
        end
        @(negedge Clk);
        obs_s6 = is_food_eaten;
        tick();
        tick();
    endtask

    task automatic do_restart();
        level_restart = 1'b1;
        tick();
        level_restart = 1'b0;
        model_restart();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int px;
        int py;
        int t;
        int guard;

        Reset_n        = 1'b1;
        frame_clk      = 1'b0;
        level_restart  = 1'b0;
        Ball_X_Pos_out = '0;
        Ball_Y_Pos_out = '0;
        model_reset();
        fill_map();
        #2;
        Reset_n = 1'b0;
        cmp_en  = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        check("rst_score",   {16'd0, score_bcd},     32'h0000);
        check("rst_pellets", {24'd0, pellets_left},  32'd150);
        check("rst_clear",   {31'd0, level_clear},   32'd0);
        check("rst_strobe",  {31'd0, is_food_eaten}, 32'd0);
        check("rst_qaddr",   {24'd0, query_addr},    32'd0);
        tick();

        // First hit on tile 21.
        frame(48, 48, 1'b0, 1'b0);
        check("t21_qaddr",    obs_q,                  32'd21);
        check("t21_strobe_e3", {31'd0, obs_s5},       32'd1);
        check("t21_strobe_e4", {31'd0, obs_s6},       32'd0);
        check("t21_score",    {16'd0, score_bcd},     32'h0010);
        check("t21_pellets",  {24'd0, pellets_left},  32'd149);

        // Sitting still must not count again.
        repeat (3) begin
            frame(48, 48, 1'b0, 1'b0);
            check("stay_nostrobe", {31'd0, obs_s5}, 32'd0);
        end
        check("stay_score", {16'd0, score_bcd}, 32'h0010);

        // Off-centre and off-map positions.
        frame(40, 48, 1'b0, 1'b0);
        check("offc_nostrobe", {31'd0, obs_s5}, 32'd0);
        check("offc_qaddr",    obs_q,           32'd21);
        frame(660, 48, 1'b0, 1'b0);
        check("col20_nostrobe", {31'd0, obs_s5}, 32'd0);
        check("col20_qaddr",    obs_q,           32'd21);

        // Restart landing on the CHECK cycle of a hit on tile 22.
        frame(80, 48, 1'b1, 1'b0);
        check("rchk_nostrobe", {31'd0, obs_s5},      32'd0);
        check("rchk_pellets",  {24'd0, pellets_left}, 32'd150);
        check("rchk_clear",    {31'd0, level_clear},  32'd0);
        check("rchk_score",    {16'd0, score_bcd},    32'h0010);
        frame(80, 48, 1'b0, 1'b0);
        check("rchk_retry",       {31'd0, obs_s5},   32'd1);
        check("rchk_retry_score", {16'd0, score_bcd}, 32'h0020);

        // Randomised frames over a partly emptied maze.
        for (int i = 0; i < NTILES; i++) map_empty[i] = ($urandom_range(0, 3) == 0);
        px = 48;
        py = 48;
        repeat (400) begin
            if ($urandom_range(0, 99) < 5) do_restart();
            if ($urandom_range(0, 3) != 0) begin
                px = $urandom_range(0, 21) * 32 +
                     (($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : 13 + $urandom_range(0, 6));
                py = $urandom_range(0, 11) * 32 +
                     (($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : 13 + $urandom_range(0, 6));
            end
            frame(px, py, ($urandom_range(0, 99) < 3), 1'b0);
        end

        // Eat a full maze.
        do_restart();
        fill_map();
        for (int k = 0; k < 150; k++) frame((k % 20) * 32 + 16, (k / 20) * 32 + 16, 1'b0, 1'b0);
        check("clr_pellets", {24'd0, pellets_left}, 32'd0);
        check("clr_flag",    {31'd0, level_clear},  32'd1);
        frame(10 * 32 + 16, 7 * 32 + 16, 1'b0, 1'b0);
        check("clr_noeat",   {31'd0, obs_s5},       32'd0);

        // Drive the score into saturation.
        do_restart();
        fill_map();
        t = 0;
        guard = 0;
        while (m_score < 9999 && guard < 2000) begin
            if (m_pellets == 0) begin
                do_restart();
                fill_map();
                t = 0;
            end
            frame((t % 20) * 32 + 16, (t / 20) * 32 + 16, 1'b0, 1'b0);
            t++;
            guard++;
        end
        check("sat_score", {16'd0, score_bcd}, 32'h9999);
        do_restart();
        fill_map();
        frame(5 * 32 + 16, 2 * 32 + 16, 1'b0, 1'b0);
        check("sat_hit",   {31'd0, obs_s5},    32'd1);
        check("sat_hold",  {16'd0, score_bcd}, 32'h9999);

        // Reset pulse during the lookup cycle of a would-be hit.
        frame(6 * 32 + 16, 2 * 32 + 16, 1'b0, 1'b1);
        check("rstl_nostrobe", {31'd0, obs_s5},       32'd0);
        check("rstl_score",    {16'd0, score_bcd},    32'h0000);
        check("rstl_pellets",  {24'd0, pellets_left}, 32'd150);
        check("rstl_clear",    {31'd0, level_clear},  32'd0);
        check("rstl_qaddr",    {24'd0, query_addr},   32'd0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
